// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and defaults for the block-transfer register file.
//   xfer_state_t : block-transfer sequencer states
//   DEF_N        : default register address width (16 registers)
//   DEF_M        : default data width
//   DEF_PC_IDX   : default index of the PC register (top of the file)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_M      = 32;
    localparam int DEF_PC_IDX = (1 << DEF_N) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

endpackage

// File: rtl/regfile_block_xfer_if.sv
// -----------------------------------------------------------------------------
// regfile_block_xfer_if
// Block-transfer channel between the load/store unit and the register file.
//   master : load/store unit side (issues requests, supplies load data)
//   slave  : register file side (sequences the mask, supplies store data)
// Signals:
//   xfer_start/xfer_load/xfer_mask       request (start sampled in IDLE only)
//   xfer_busy/xfer_done                  sequencer status / completion pulse
//   xfer_idx                             register currently being moved
//   xfer_rdata/xfer_valid/xfer_ready     store beat (registers -> memory)
//   xfer_wdata/xfer_wvalid/xfer_wready   load beat  (memory -> registers)
// -----------------------------------------------------------------------------
interface regfile_block_xfer_if
    import regfile_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
);
    localparam int NREGS = 1 << N;

    logic             xfer_start;
    logic             xfer_load;
    logic [NREGS-1:0] xfer_mask;
    logic             xfer_busy;
    logic [N-1:0]     xfer_idx;
    logic [M-1:0]     xfer_rdata;
    logic             xfer_valid;
    logic             xfer_ready;
    logic [M-1:0]     xfer_wdata;
    logic             xfer_wvalid;
    logic             xfer_wready;
    logic             xfer_done;

    modport master (
        output xfer_start, xfer_load, xfer_mask,
        output xfer_ready, xfer_wdata, xfer_wvalid,
        input  xfer_busy, xfer_idx, xfer_rdata, xfer_valid,
        input  xfer_wready, xfer_done
    );

    modport slave (
        input  xfer_start, xfer_load, xfer_mask,
        input  xfer_ready, xfer_wdata, xfer_wvalid,
        output xfer_busy, xfer_idx, xfer_rdata, xfer_valid,
        output xfer_wready, xfer_done
    );

endinterface

// File: rtl/regfile_block_xfer_lsb_finder.sv
// -----------------------------------------------------------------------------
// lsb_finder
// Combinational lowest-set-bit encoder used to walk a register mask in
// ascending order.
//   mask : 2^N-bit register list
//   idx  : index of the lowest set bit (0 when mask is empty)
//   any  : at least one bit of mask is set
// -----------------------------------------------------------------------------
module lsb_finder
    import regfile_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [(1<<N)-1:0] mask,
    output logic [N-1:0]      idx,
    output logic              any
);
    localparam int NREGS = 1 << N;

    // Scan from the top down so the last hit, the lowest bit, wins.
    always_comb begin
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = N'(i);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/regfile_block_xfer.sv
// -----------------------------------------------------------------------------
// regfile_block_xfer
// 2^N x M register file with two combinational read ports, one write port,
// a PC register refreshed from fetch every cycle, and an LDM/STM-style
// block-transfer sequencer on the xfer channel.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   we3/a3/wd3   writeback port
//   a1/rd1       read port 1 (combinational)
//   a2/rd2       read port 2 (combinational)
//   r15          next PC value from fetch (loaded every cycle unless overridden)
//   xfer         block-transfer channel (slave side)
// Build option:
//   REGFILE_BYPASS_EN  when defined, rd1/rd2 forward wd3 if we3 is high and
//                      the read address matches a3 (write-through). Otherwise
//                      a write becomes visible on the next cycle.
// -----------------------------------------------------------------------------
module regfile_block_xfer
    import regfile_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int M      = DEF_M,
    parameter int PC_IDX = (1 << N) - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we3,
    input  logic [N-1:0]          a1,
    input  logic [N-1:0]          a2,
    input  logic [N-1:0]          a3,
    input  logic [M-1:0]          wd3,
    input  logic [M-1:0]          r15,
    output logic [M-1:0]          rd1,
    output logic [M-1:0]          rd2,
    regfile_block_xfer_if.slave   xfer
);
    localparam int NREGS = 1 << N;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [M-1:0]     regs_reg  [NREGS];
    logic [M-1:0]     regs_next [NREGS];
    xfer_state_t      state_reg, state_next;
    logic [NREGS-1:0] mask_reg, mask_next;

    // ---------------------------------------------------------------------
    // Mask walker: current register is the lowest bit still pending
    // ---------------------------------------------------------------------
    logic [N-1:0]     lsb_idx;
    logic             lsb_any;
    logic [NREGS-1:0] idx_onehot;

    lsb_finder #(.N(N)) u_lsb_finder (
        .mask (mask_reg),
        .idx  (lsb_idx),
        .any  (lsb_any)
    );

    assign idx_onehot = {{(NREGS-1){1'b0}}, 1'b1} << lsb_idx;

    // ---------------------------------------------------------------------
    // Channel outputs
    // ---------------------------------------------------------------------
    logic in_store, in_load;
    logic store_hs, load_hs;

    assign in_store = (state_reg == STORE) && lsb_any;
    assign in_load  = (state_reg == LOAD)  && lsb_any;

    assign xfer.xfer_busy   = (state_reg != IDLE);
    assign xfer.xfer_valid  = in_store;
    // Writeback owns the single write port; a load beat waits while we3 is up.
    assign xfer.xfer_wready = in_load && !we3;
    assign xfer.xfer_done   = (state_reg == DONE);
    assign xfer.xfer_idx    = (in_store || in_load) ? lsb_idx : '0;
    // Stored (pre-edge) value, so a same-cycle port-3 write is not seen here.
    assign xfer.xfer_rdata  = in_store ? regs_reg[lsb_idx] : '0;

    assign store_hs = in_store && xfer.xfer_ready;
    assign load_hs  = xfer.xfer_wready && xfer.xfer_wvalid;

    // ---------------------------------------------------------------------
    // Sequencer FSM: next-state logic. The STORE/LOAD state itself records
    // the direction latched at start, so no separate direction flop exists.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        case (state_reg)
            IDLE: begin
                if (xfer.xfer_start) begin
                    mask_next = xfer.xfer_mask;
                    if (xfer.xfer_mask == '0) begin
                        state_next = DONE;
                    end else if (xfer.xfer_load) begin
                        state_next = LOAD;
                    end else begin
                        state_next = STORE;
                    end
                end
            end
            STORE, LOAD: begin
                if (!lsb_any) begin
                    state_next = DONE;
                end else if ((state_reg == STORE) ? store_hs : load_hs) begin
                    mask_next = mask_reg & ~idx_onehot;
                    if ((mask_reg & ~idx_onehot) == '0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
        end
    end

    // ---------------------------------------------------------------------
    // Per-register next value. Port 3 always has priority over a load beat;
    // the PC falls back to the fetch value instead of holding.
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic port3_hit;
        logic load_hit;

        assign port3_hit = we3 && (a3 == N'(gi));
        assign load_hit  = load_hs && (lsb_idx == N'(gi));

        if (gi == PC_IDX) begin : g_pc
            assign regs_next[gi] = port3_hit ? wd3 :
                                   load_hit  ? xfer.xfer_wdata :
                                               r15;
        end else begin : g_gpr
            assign regs_next[gi] = port3_hit ? wd3 :
                                   load_hit  ? xfer.xfer_wdata :
                                               regs_reg[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= regs_next[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    assign rd1 = (we3 && (a1 == a3)) ? wd3 : regs_reg[a1];
    assign rd2 = (we3 && (a2 == a3)) ? wd3 : regs_reg[a2];
`else
    assign rd1 = regs_reg[a1];
    assign rd2 = regs_reg[a2];
`endif

endmodule

// File: tb/tb_regfile_block_xfer.sv
// -----------------------------------------------------------------------------
// tb_regfile_block_xfer
// Directed self-checking bench for regfile_block_xfer. Inputs change 1 ns
// after a rising edge; outputs are sampled 1 ns later, well before the next
// edge. Expectations for the write-through read path follow
// REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_block_xfer;
    localparam int N = 4;
    localparam int M = 32;

    logic         clk;
    logic         reset;
    logic         we3;
    logic [N-1:0] a1, a2, a3;
    logic [M-1:0] wd3, r15;
    logic [M-1:0] rd1, rd2;

    int tests_run;
    int tests_failed;

    regfile_block_xfer_if #(.N(N), .M(M)) xif ();

    regfile_block_xfer #(.N(N), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .wd3   (wd3),
        .r15   (r15),
        .rd1   (rd1),
        .rd2   (rd2),
        .xfer  (xif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0; r15 = 32'h100; a1 = 4'd15; a2 = 4'd3;
        tick(); tick(); settle();
        tests_run++; if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL reset_pc rd1=%h exp=%h", rd1, 32'h0); end
        tests_run++; if ({xif.xfer_busy, xif.xfer_valid, xif.xfer_wready, xif.xfer_done} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags busy/valid/wready/done=%b exp=0000",
                {xif.xfer_busy, xif.xfer_valid, xif.xfer_wready, xif.xfer_done}); end
        tests_run++; if (xif.xfer_idx !== 4'd0 || xif.xfer_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_idx_rdata idx=%0d rdata=%h exp=0/0", xif.xfer_idx, xif.xfer_rdata); end
        reset = 1'b1;
        tick(); settle();
        tests_run++; if (rd1 !== 32'h100) begin tests_failed++; $display("FAIL pc_after_reset rd1=%h exp=%h", rd1, 32'h100); end
        tests_run++; if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL r3_after_reset rd2=%h exp=%h", rd2, 32'h0); end
        $display("[TB] reset: pc=%h r3=%h", rd1, rd2);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_pc_write();
        we3 = 1'b1; a3 = 4'd15; wd3 = 32'hDEAD; r15 = 32'h200; a1 = 4'd15;
        tick(); we3 = 1'b0; r15 = 32'h204; settle();
        tests_run++; if (rd1 !== 32'hDEAD) begin tests_failed++; $display("FAIL pc_port3_priority rd1=%h exp=%h", rd1, 32'hDEAD); end
        tick(); settle();
        tests_run++; if (rd1 !== 32'h204) begin tests_failed++; $display("FAIL pc_follows_r15 rd1=%h exp=%h", rd1, 32'h204); end
        $display("[TB] pc write: pc=%h", rd1);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_store_burst();
        logic       rdy_seq [4];
        logic [3:0] exp_idx [4];
        logic [31:0] exp_dat [4];
        int beats;
        rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_idx = '{4'd1, 4'd4, 4'd4, 4'd15};
        exp_dat = '{32'h11, 32'h44, 32'h44, 32'h300};
        beats = 0;
        // Preload regs 1 and 4 via port 3; PC follows r15 = 0x300.
        r15 = 32'h300;
        we3 = 1'b1; a3 = 4'd1; wd3 = 32'h11; tick();
        a3 = 4'd4; wd3 = 32'h44; tick();
        we3 = 1'b0; a1 = 4'd1; a2 = 4'd4; settle();
        tests_run++; if (rd1 !== 32'h11 || rd2 !== 32'h44) begin
            tests_failed++; $display("FAIL store_preload r1=%h r4=%h exp=11/44", rd1, rd2); end
        xif.xfer_start = 1'b1; xif.xfer_load = 1'b0; xif.xfer_mask = 16'h8012;
        tick();
        xif.xfer_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            xif.xfer_ready = rdy_seq[c]; settle();
            tests_run++; if (xif.xfer_valid !== 1'b1 || xif.xfer_idx !== exp_idx[c] || xif.xfer_rdata !== exp_dat[c] || xif.xfer_done !== 1'b0) begin
                tests_failed++; $display("FAIL store_beat%0d valid=%b idx=%0d data=%h done=%b exp=1/%0d/%h/0",
                    c, xif.xfer_valid, xif.xfer_idx, xif.xfer_rdata, xif.xfer_done, exp_idx[c], exp_dat[c]); end
            if (xif.xfer_valid && xif.xfer_ready) begin
                beats++;
                $display("[TB] store beat idx=%0d data=%h", xif.xfer_idx, xif.xfer_rdata);
            end
            tick();
        end
        xif.xfer_ready = 1'b0; settle();
        tests_run++; if (xif.xfer_done !== 1'b1 || xif.xfer_valid !== 1'b0) begin
            tests_failed++; $display("FAIL store_done done=%b valid=%b exp=1/0", xif.xfer_done, xif.xfer_valid); end
        tests_run++; if (beats !== 3) begin tests_failed++; $display("FAIL store_beat_count got=%0d exp=3", beats); end
        tick(); settle();
        tests_run++; if (xif.xfer_done !== 1'b0 || xif.xfer_busy !== 1'b0) begin
            tests_failed++; $display("FAIL store_idle done=%b busy=%b exp=0/0", xif.xfer_done, xif.xfer_busy); end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_zero_mask_and_ignored_start();
        xif.xfer_start = 1'b1; xif.xfer_load = 1'b0; xif.xfer_mask = 16'h0000; xif.xfer_ready = 1'b1;
        tick();
        xif.xfer_start = 1'b0; settle();
        tests_run++; if (xif.xfer_done !== 1'b1 || xif.xfer_valid !== 1'b0 || xif.xfer_busy !== 1'b1) begin
            tests_failed++; $display("FAIL zero_mask_done done=%b valid=%b busy=%b exp=1/0/1",
                xif.xfer_done, xif.xfer_valid, xif.xfer_busy); end
        $display("[TB] zero-mask transfer done=%b", xif.xfer_done);
        tick(); settle();
        tests_run++; if (xif.xfer_done !== 1'b0 || xif.xfer_busy !== 1'b0) begin
            tests_failed++; $display("FAIL zero_mask_idle done=%b busy=%b exp=0/0", xif.xfer_done, xif.xfer_busy); end
        // Store of reg 1 stalled; a second (load) start during STORE must be ignored.
        xif.xfer_ready = 1'b0; xif.xfer_start = 1'b1; xif.xfer_mask = 16'h0002;
        tick();
        xif.xfer_mask = 16'h0010; xif.xfer_load = 1'b1;
        tick(); tick(); settle();
        tests_run++; if (xif.xfer_valid !== 1'b1 || xif.xfer_idx !== 4'd1 || xif.xfer_wready !== 1'b0) begin
            tests_failed++; $display("FAIL ignored_start valid=%b idx=%0d wready=%b exp=1/1/0",
                xif.xfer_valid, xif.xfer_idx, xif.xfer_wready); end
        xif.xfer_start = 1'b0; xif.xfer_load = 1'b0; xif.xfer_ready = 1'b1; settle();
        $display("[TB] store beat idx=%0d data=%h", xif.xfer_idx, xif.xfer_rdata);
        tick(); xif.xfer_ready = 1'b0; settle();
        tests_run++; if (xif.xfer_done !== 1'b1 || xif.xfer_valid !== 1'b0) begin
            tests_failed++; $display("FAIL ignored_start_done done=%b valid=%b exp=1/0", xif.xfer_done, xif.xfer_valid); end
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_load_conflict();
        xif.xfer_start = 1'b1; xif.xfer_load = 1'b1; xif.xfer_mask = 16'h000C;
        tick();
        xif.xfer_start = 1'b0;
        xif.xfer_wvalid = 1'b1; xif.xfer_wdata = 32'hA;
        we3 = 1'b1; a3 = 4'd7; wd3 = 32'h77; settle();
        tests_run++; if (xif.xfer_wready !== 1'b0 || xif.xfer_idx !== 4'd2) begin
            tests_failed++; $display("FAIL load_conflict wready=%b idx=%0d exp=0/2", xif.xfer_wready, xif.xfer_idx); end
        tick();
        we3 = 1'b0; settle();
        tests_run++; if (xif.xfer_wready !== 1'b1 || xif.xfer_idx !== 4'd2) begin
            tests_failed++; $display("FAIL load_beat0 wready=%b idx=%0d exp=1/2", xif.xfer_wready, xif.xfer_idx); end
        $display("[TB] load beat idx=%0d data=%h", xif.xfer_idx, xif.xfer_wdata);
        tick();
        xif.xfer_wdata = 32'hB; settle();
        tests_run++; if (xif.xfer_wready !== 1'b1 || xif.xfer_idx !== 4'd3) begin
            tests_failed++; $display("FAIL load_beat1 wready=%b idx=%0d exp=1/3", xif.xfer_wready, xif.xfer_idx); end
        $display("[TB] load beat idx=%0d data=%h", xif.xfer_idx, xif.xfer_wdata);
        tick();
        xif.xfer_wvalid = 1'b0; settle();
        tests_run++; if (xif.xfer_done !== 1'b1) begin tests_failed++; $display("FAIL load_done done=%b exp=1", xif.xfer_done); end
        a1 = 4'd2; a2 = 4'd3; settle();
        tests_run++; if (rd1 !== 32'hA || rd2 !== 32'hB) begin
            tests_failed++; $display("FAIL load_data r2=%h r3=%h exp=a/b", rd1, rd2); end
        a1 = 4'd7; settle();
        tests_run++; if (rd1 !== 32'h77) begin tests_failed++; $display("FAIL load_port3 r7=%h exp=%h", rd1, 32'h77); end
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_back_to_back();
        xif.xfer_ready = 1'b1; xif.xfer_load = 1'b0;
        xif.xfer_start = 1'b1; xif.xfer_mask = 16'h0002;
        tick();
        xif.xfer_start = 1'b0; settle();
        tests_run++; if (xif.xfer_valid !== 1'b1 || xif.xfer_idx !== 4'd1 || xif.xfer_rdata !== 32'h11) begin
            tests_failed++; $display("FAIL b2b_first valid=%b idx=%0d data=%h exp=1/1/11",
                xif.xfer_valid, xif.xfer_idx, xif.xfer_rdata); end
        $display("[TB] store beat idx=%0d data=%h", xif.xfer_idx, xif.xfer_rdata);
        tick();
        // Start held through DONE: only the following IDLE cycle accepts it.
        xif.xfer_start = 1'b1; xif.xfer_mask = 16'h0010; settle();
        tests_run++; if (xif.xfer_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done done=%b exp=1", xif.xfer_done); end
        tick(); settle();
        tests_run++; if (xif.xfer_busy !== 1'b0 || xif.xfer_done !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_idle busy=%b done=%b exp=0/0", xif.xfer_busy, xif.xfer_done); end
        tick();
        xif.xfer_start = 1'b0; settle();
        tests_run++; if (xif.xfer_valid !== 1'b1 || xif.xfer_idx !== 4'd4 || xif.xfer_rdata !== 32'h44) begin
            tests_failed++; $display("FAIL b2b_second valid=%b idx=%0d data=%h exp=1/4/44",
                xif.xfer_valid, xif.xfer_idx, xif.xfer_rdata); end
        $display("[TB] store beat idx=%0d data=%h", xif.xfer_idx, xif.xfer_rdata);
        tick(); tick();
        xif.xfer_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_bypass();
        logic [31:0] exp_same;
        we3 = 1'b1; a3 = 4'd5; wd3 = 32'h50; tick();
        wd3 = 32'h55; a1 = 4'd5; a2 = 4'd5; settle();
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h55;
`else
        exp_same = 32'h50;
`endif
        tests_run++; if (rd1 !== exp_same || rd2 !== exp_same) begin
            tests_failed++; $display("FAIL bypass_same_cycle rd1=%h rd2=%h exp=%h", rd1, rd2, exp_same); end
        tick();
        we3 = 1'b0; settle();
        tests_run++; if (rd1 !== 32'h55) begin tests_failed++; $display("FAIL bypass_next_cycle rd1=%h exp=%h", rd1, 32'h55); end
        $display("[TB] write r5: same-cycle=%h next=%h", exp_same, rd1);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid_load();
        int nonzero;
        xif.xfer_start = 1'b1; xif.xfer_load = 1'b1; xif.xfer_mask = 16'h0006;
        tick();
        xif.xfer_start = 1'b0; xif.xfer_wvalid = 1'b1; xif.xfer_wdata = 32'h99; settle();
        tests_run++; if (xif.xfer_wready !== 1'b1 || xif.xfer_idx !== 4'd1) begin
            tests_failed++; $display("FAIL midload_beat wready=%b idx=%0d exp=1/1", xif.xfer_wready, xif.xfer_idx); end
        $display("[TB] load beat idx=%0d data=%h", xif.xfer_idx, xif.xfer_wdata);
        tick();
        reset = 1'b0; xif.xfer_wvalid = 1'b0;
        tick(); settle();
        tests_run++; if (xif.xfer_busy !== 1'b0 || xif.xfer_done !== 1'b0 || xif.xfer_wready !== 1'b0) begin
            tests_failed++; $display("FAIL midload_abort busy=%b done=%b wready=%b exp=0/0/0",
                xif.xfer_busy, xif.xfer_done, xif.xfer_wready); end
        nonzero = 0;
        for (int r = 0; r < 16; r++) begin
            a1 = 4'(r); settle();
            if (rd1 !== 32'h0) nonzero++;
        end
        tests_run++; if (nonzero !== 0) begin tests_failed++; $display("FAIL midload_regs_cleared nonzero=%0d exp=0", nonzero); end
        reset = 1'b1; r15 = 32'h0;
        tick(); settle();
        tests_run++; if (xif.xfer_done !== 1'b0 || xif.xfer_busy !== 1'b0) begin
            tests_failed++; $display("FAIL midload_no_done done=%b busy=%b exp=0/0", xif.xfer_done, xif.xfer_busy); end
        $display("[TB] reset mid-load: busy=%b done=%b", xif.xfer_busy, xif.xfer_done);
    endtask

    // ---------------------------------------------------------------------
    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; r15 = '0;
        xif.xfer_start = 1'b0; xif.xfer_load = 1'b0; xif.xfer_mask = '0;
        xif.xfer_ready = 1'b0; xif.xfer_wdata = '0; xif.xfer_wvalid = 1'b0;
        test_reset();
        test_pc_write();
        test_store_burst();
        test_zero_mask_and_ignored_start();
        test_load_conflict();
        test_back_to_back();
        test_bypass();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
